ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit directly upstream of the single-cycle RV64 core; supplies each 32-bit instruction and its PC.
- Owns the fetch PC and issues one word request at a time to instruction memory over a valid/ready request channel with a variable-latency response channel.
- Buffers returned words in a small FIFO and presents them to the core with valid/ready.
- Core branches and jumps arrive as a redirect, which flushes buffered and in-flight work.

Parameters:
- RESET_PC, 64'h0000000080000000, fetch PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- redirect_valid  in  1  core taken branch/jump; restart fetch.
- redirect_pc  in  64  new fetch PC; bits [1:0] ignored, treated as 0.
- mem_req_valid  out  1  fetch request valid.
- mem_req_addr  out  64  word address of the request; bits [1:0] always 0.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_resp_valid  in  1  response data valid; exactly one response per accepted request, in order.
- mem_resp_data  in  32  instruction word.
- inst_valid  out  1  FIFO head valid.
- inst  out  32  FIFO head instruction.
- inst_pc  out  64  PC of the FIFO head.
- inst_ready  in  1  core consumes the head this cycle.

Behaviour:
- Reset (rst=1 at a clk edge):
  - fetch_pc = RESET_PC; FSM = IDLE; FIFO empty; drop flag = 0.
  - mem_req_valid = 0, inst_valid = 0. mem_req_addr, inst and inst_pc = 0.
  - Reset mid-transaction abandons it. A response arriving after reset with no request accepted since reset is ignored.
- Maximum one outstanding request (accepted but not yet responded).
- FSM state IDLE:
  - Go to REQ when (FIFO count + 0) < FIFO_DEPTH and no redirect this cycle.
- FSM state REQ:
  - mem_req_valid = 1; mem_req_addr = fetch_pc.
  - Address and valid stay stable until mem_req_ready. The request is never retracted.
  - On acceptance: record req_pc = fetch_pc, fetch_pc += 4 (64-bit wrap), go to WAIT.
- FSM state WAIT:
  - On mem_resp_valid with drop = 0: push {mem_resp_data, req_pc} into the FIFO.
  - Then go to REQ if the FIFO has space after this push/pop; otherwise go to IDLE.
  - The space check at issue guarantees the push never overflows.
- Redirect:
  - Has priority over everything in its cycle.
  - FIFO is flushed; a simultaneous inst_ready pop is irrelevant.
  - fetch_pc = {redirect_pc[63:2], 2'b00}.
- Redirect, per state:
  - IDLE: next state REQ. mem_req_valid = 1 with the new PC at t+1.
  - REQ (not accepted): set drop. The old request completes normally, and its response is discarded in WAIT. fetch_pc is not incremented at that acceptance, so the next request uses the redirect PC.
  - WAIT: set drop. A response in the same cycle as the redirect is discarded.
  - Drop clears when the dropped response arrives. Then the FSM goes to REQ with the redirect PC.
  - A second redirect while drop is set only updates fetch_pc.
- Latency:
  - mem_resp_valid at cycle r gives inst_valid at r+1. The FIFO is registered, with no bypass.
  - Zero-wait memory (accept at t, respond at t+1) sustains one instruction per 2 cycles.
- FIFO:
  - Push and pop in the same cycle are allowed when non-empty.
  - inst and inst_pc hold stable while inst_valid=1 and inst_ready=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Responses with mem_resp_valid outside WAIT are ignored.

Decomposition:
- Package ifu_pkg:
  - RESET_PC default constant.
  - FSM state enum {IDLE, REQ, WAIT}.
  - Instruction width 32 and XLEN 64 constants.
  - FIFO entry struct {inst[31:0], pc[63:0]}.
- Sub-module ifu_fifo: synchronous FIFO parameterised by depth, with flush input, count output, and push/pop/full/empty.

Test Plan:
- Reset, then zero-wait memory:
  - First request addr 0x80000000 at the cycle after rst drops.
  - inst_valid with inst_pc 0x80000000, then 0x80000004, 0x80000008, all in order.
- Core stalls (inst_ready=0):
  - FIFO fills to 2 entries; mem_req_valid stays 0.
  - Head stays 0x80000000 until inst_ready=1; the next request issues after the pop.
- Memory holds mem_req_ready=0 for 5 cycles: mem_req_valid and mem_req_addr are stable throughout.
- Redirect to 0x80000100 in WAIT with a 3-cycle response latency:
  - Stale response dropped; FIFO flushed.
  - Next inst_pc seen is 0x80000100.
- Redirect to 0x80000203 while IDLE (FIFO full):
  - FIFO cleared.
  - mem_req_addr = 0x80000200 at t+1.
- rst asserted while in WAIT, response arrives a cycle later: no FIFO push; fetch restarts at 0x80000000.

Source files
------------

// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Purpose  : Shared types and constants for the instruction fetch unit:
//            datapath widths, reset PC, fetch FSM state encoding and the
//            instruction buffer entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    localparam int          c_xlen     = 64;
    localparam int          c_ilen     = 32;
    localparam logic [63:0] c_reset_pc = 64'h0000_0000_8000_0000;

    // Fetch FSM encoding, explicit width and values
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // One buffered instruction together with the PC it was fetched from
    typedef struct packed {
        logic [c_ilen-1:0] inst;
        logic [c_xlen-1:0] pc;
    } fifo_entry_t;

endpackage : ifu_pkg
`default_nettype wire

// File: rtl/ifu_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fifo
// Purpose  : Registered synchronous FIFO for fetched instructions. No
//            bypass: a push becomes visible at the head one cycle later.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_flush         - empty the FIFO (wins over push/pop)
//            i_push/i_push_data - write an entry (ignored when full)
//            i_pop           - retire the head entry (ignored when empty)
//            o_head          - current head entry
//            o_count         - occupancy 0..DEPTH
//            o_full/o_empty  - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fifo_entry_t              i_push_data,
    input  logic                     i_pop,
    output fifo_entry_t              o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    fifo_entry_t          r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    assign o_full    = (r_count == c_cnt_w'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // DEPTH is a power of two, so pointers wrap naturally at their width
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop_ok);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : ifu_fifo
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction fetch unit. Owns the fetch PC, issues one word
//            request at a time to instruction memory, buffers returned words
//            and presents them to the core. A redirect flushes buffered work
//            and discards the response of any request already in flight.
// Ports    : clk, rst                          - clock, sync active-high reset
//            redirect_valid/redirect_pc        - restart fetch at a new PC
//            mem_req_valid/addr/ready          - request channel
//            mem_resp_valid/data               - in-order response channel
//            inst_valid/inst/inst_pc/inst_ready - instruction channel to core
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = c_reset_pc,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid,
    input  logic [c_xlen-1:0]    redirect_pc,
    output logic                 mem_req_valid,
    output logic [c_xlen-1:0]    mem_req_addr,
    input  logic                 mem_req_ready,
    input  logic                 mem_resp_valid,
    input  logic [c_ilen-1:0]    mem_resp_data,
    output logic                 inst_valid,
    output logic [c_ilen-1:0]    inst,
    output logic [c_xlen-1:0]    inst_pc,
    input  logic                 inst_ready
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_xlen-1:0]    r_fetch_pc;
    logic [c_xlen-1:0]    w_fetch_pc_nxt;
    // Address of the request being presented / in flight; doubles as the PC
    // tagged onto its response.
    logic [c_xlen-1:0]    r_req_addr;
    // Set while the in-flight response belongs to a pre-redirect stream
    logic                 r_drop;
    logic                 w_drop_nxt;

    logic [c_xlen-1:0]    w_redirect_pc;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_has_space;
    logic [c_cnt_w-1:0]   w_count;
    logic [c_cnt_w-1:0]   w_count_after;
    fifo_entry_t          w_push_entry;
    fifo_entry_t          w_head;

    assign w_redirect_pc = redirect_pc & ~64'h3;
    assign w_accept      = (r_state == ST_REQ) && mem_req_ready;
    assign w_push        = (r_state == ST_WAIT) && mem_resp_valid && !r_drop && !redirect_valid;
    assign w_pop         = inst_ready && !w_empty && !redirect_valid;
    assign w_count_after = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_has_space   = (w_count_after < c_cnt_w'(FIFO_DEPTH));

    assign w_push_entry.inst = mem_resp_data;
    assign w_push_entry.pc   = r_req_addr;

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_drop     <= 1'b0;
            r_req_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_drop     <= w_drop_nxt;
            // Latch the address only on entry to REQ so it stays stable
            // until accepted, even if a redirect moves fetch_pc meanwhile.
            if ((w_state_nxt == ST_REQ) && (r_state != ST_REQ)) begin
                r_req_addr <= w_fetch_pc_nxt;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_drop_nxt     = r_drop;
        case (r_state)
            ST_IDLE: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_state_nxt    = ST_REQ;
                end else if (!w_full) begin
                    w_state_nxt    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    // The presented request must still complete; mark its
                    // response for discard.
                    w_fetch_pc_nxt = w_redirect_pc;
                    w_drop_nxt     = 1'b1;
                    if (w_accept) begin
                        w_state_nxt = ST_WAIT;
                    end
                end else if (w_accept) begin
                    w_state_nxt = ST_WAIT;
                    // With drop set, fetch_pc already holds the redirect
                    // target and must not advance past it.
                    if (!r_drop) begin
                        w_fetch_pc_nxt = r_fetch_pc + 64'd4;
                    end
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    w_fetch_pc_nxt = w_redirect_pc;
                    if (mem_resp_valid) begin
                        // Outstanding request retires now, nothing left to drop
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_drop_nxt  = 1'b1;
                    end
                end else if (mem_resp_valid) begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = w_has_space ? ST_REQ : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        mem_req_valid = (r_state == ST_REQ);
        mem_req_addr  = (r_state == ST_REQ) ? r_req_addr : '0;
        inst_valid    = !w_empty;
        inst          = w_head.inst;
        inst_pc       = w_head.pc;
    end

endmodule : ifu_fetch
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch
// Purpose  : Self-checking bench for ifu_fetch. A behavioural memory returns
//            a word derived from each accepted address after a chosen
//            latency; an architectural model tracks the PC the core expects
//            next (sequential, restarted by redirects) and checks every
//            consumed instruction against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;
    import ifu_pkg::*;

    localparam logic [63:0] c_rst_pc = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;

    always #5 clk = ~clk;

    ifu_fetch #(
        .RESET_PC   (c_rst_pc),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Memory model: a single pending response slot
    bit          pend_valid;
    logic [63:0] pend_addr;
    int          pend_cnt;

    // Architectural model: PC of the next instruction the core should see
    logic [63:0] exp_pc;
    logic [63:0] cons_pc [$];
    int          cons_cyc [$];

    // Previous-cycle observations for stability properties
    bit          p_ok;
    bit          p_req_valid, p_req_ready, p_inst_valid, p_inst_ready, p_redir;
    logic [63:0] p_req_addr, p_inst_pc;
    logic [31:0] p_inst;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic reset_model();
        pend_valid = 1'b0;
        pend_cnt   = 0;
        exp_pc     = c_rst_pc;
        p_ok       = 1'b0;
        cons_pc.delete();
        cons_cyc.delete();
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        inst_ready     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        reset_model();
    endtask

    // One clock cycle: drive inputs, check properties, update models.
    task automatic run_cycle(input bit rdy, input int lat, input bit irdy,
                             input bit redir, input logic [63:0] rpc);
        bit acc, rsp;
        rsp            = pend_valid && (pend_cnt == 0);
        mem_resp_valid = rsp;
        mem_resp_data  = rsp ? mem_word(pend_addr) : 32'h0;
        mem_req_ready  = rdy;
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #2;
        if (p_ok && p_req_valid && !p_req_ready) begin
            check("req_hold_valid", mem_req_valid, 1);
            check("req_hold_addr", mem_req_addr, p_req_addr);
        end
        if (p_ok && p_inst_valid && !p_inst_ready && !p_redir) begin
            check("head_hold_valid", inst_valid, 1);
            check("head_hold_pc", inst_pc, p_inst_pc);
            check("head_hold_inst", inst, p_inst);
        end
        if (p_ok && p_redir) check("flush_empty", inst_valid, 0);
        if (mem_req_valid) check("req_align", mem_req_addr[1:0], 0);
        acc = mem_req_valid && rdy;
        if (redir) begin
            exp_pc = {rpc[63:2], 2'b00};
        end else if (inst_valid && irdy) begin
            check("stream_pc", inst_pc, exp_pc);
            check("stream_inst", inst, mem_word(exp_pc));
            cons_pc.push_back(inst_pc);
            cons_cyc.push_back(cyc);
            exp_pc = exp_pc + 64'd4;
        end
        if (rsp) pend_valid = 1'b0;
        else if (pend_valid) pend_cnt--;
        if (acc) begin
            check("one_outstanding", pend_valid, 0);
            pend_valid = 1'b1;
            pend_addr  = mem_req_addr;
            pend_cnt   = lat - 1;
        end
        p_ok         = 1'b1;
        p_req_valid  = mem_req_valid;
        p_req_ready  = rdy;
        p_req_addr   = mem_req_addr;
        p_inst_valid = inst_valid;
        p_inst_ready = irdy;
        p_redir      = redir;
        p_inst       = inst;
        p_inst_pc    = inst_pc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t_req;
        bit          rdy, irdy, redir;
        int          lat;
        logic [63:0] rpc;

        // ---- Reset state and zero-wait streaming ----
        do_reset();
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_req_addr", mem_req_addr, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        run_cycle(1, 1, 1, 0, 64'h0);
        check("first_req_valid", mem_req_valid, 1);
        check("first_req_addr", mem_req_addr, c_rst_pc);
        t_req = cyc;
        repeat (12) run_cycle(1, 1, 1, 0, 64'h0);
        check("zw_count", cons_pc.size() >= 3, 1);
        if (cons_pc.size() >= 3) begin
            check("zw_pc0", cons_pc[0], c_rst_pc);
            check("zw_pc1", cons_pc[1], c_rst_pc + 64'd4);
            check("zw_pc2", cons_pc[2], c_rst_pc + 64'd8);
            check("zw_first_lat", cons_cyc[0] - t_req, 2);
            check("zw_rate1", cons_cyc[1] - cons_cyc[0], 2);
            check("zw_rate2", cons_cyc[2] - cons_cyc[1], 2);
        end

        // ---- Core stall fills the buffer ----
        do_reset();
        repeat (10) run_cycle(1, 1, 0, 0, 64'h0);
        check("stall_req_idle", mem_req_valid, 0);
        check("stall_head_valid", inst_valid, 1);
        check("stall_head_pc", inst_pc, c_rst_pc);
        run_cycle(1, 1, 1, 0, 64'h0);
        check("pop_next_pc", inst_pc, c_rst_pc + 64'd4);
        check("pop_req_still_idle", mem_req_valid, 0);
        run_cycle(0, 1, 0, 0, 64'h0);
        check("pop_req_valid", mem_req_valid, 1);
        check("pop_req_addr", mem_req_addr, c_rst_pc + 64'd8);

        // ---- Memory back-pressure holds the request ----
        do_reset();
        run_cycle(0, 1, 1, 0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", mem_req_valid, 1);
            check("bp_addr", mem_req_addr, c_rst_pc);
            run_cycle(0, 1, 1, 0, 64'h0);
        end
        repeat (8) run_cycle(1, 1, 1, 0, 64'h0);
        check("bp_progress", cons_pc.size() >= 2, 1);

        // ---- Redirect while waiting on a 3-cycle response ----
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if (pend_valid && pend_addr == c_rst_pc + 64'd4) break;
            run_cycle(1, 3, 0, 0, 64'h0);
        end
        check("wr_reach_wait", pend_valid && (pend_addr == c_rst_pc + 64'd4), 1);
        check("wr_pre_valid", inst_valid, 1);
        run_cycle(1, 3, 1, 1, 64'h0000_0000_8000_0100);
        check("wr_flushed", inst_valid, 0);
        for (int i = 0; i < 40; i++) begin
            if (cons_pc.size() > 0) break;
            run_cycle(1, 3, 1, 0, 64'h0);
        end
        check("wr_got_inst", cons_pc.size() > 0, 1);
        if (cons_pc.size() > 0) check("wr_first_pc", cons_pc[0], 64'h0000_0000_8000_0100);

        // ---- Redirect while idle with a full buffer ----
        do_reset();
        repeat (10) run_cycle(1, 1, 0, 0, 64'h0);
        check("ir_full_valid", inst_valid, 1);
        check("ir_idle", mem_req_valid, 0);
        run_cycle(1, 1, 0, 1, 64'h0000_0000_8000_0203);
        check("ir_flushed", inst_valid, 0);
        check("ir_req_valid", mem_req_valid, 1);
        check("ir_req_addr", mem_req_addr, 64'h0000_0000_8000_0200);
        repeat (8) run_cycle(1, 1, 1, 0, 64'h0);
        check("ir_got_inst", cons_pc.size() > 0, 1);
        if (cons_pc.size() > 0) check("ir_first_pc", cons_pc[0], 64'h0000_0000_8000_0200);

        // ---- Reset while waiting; stale response afterwards ----
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (pend_valid) break;
            run_cycle(1, 3, 0, 0, 64'h0);
        end
        check("rw_in_wait", pend_valid, 1);
        rst            = 1'b1;
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        inst_ready     = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst            = 1'b0;
        reset_model();
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        cyc++;
        mem_resp_valid = 1'b0;
        check("rw_no_push", inst_valid, 0);
        check("rw_req_valid", mem_req_valid, 1);
        check("rw_req_addr", mem_req_addr, c_rst_pc);
        repeat (8) run_cycle(1, 1, 1, 0, 64'h0);
        check("rw_got_inst", cons_pc.size() > 0, 1);
        if (cons_pc.size() > 0) check("rw_first_pc", cons_pc[0], c_rst_pc);

        // ---- Randomized traffic ----
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            lat   = int'($urandom_range(1, 4));
            irdy  = ($urandom_range(0, 4) > 1);
            redir = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0)
                rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else
                rpc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
            run_cycle(rdy, lat, irdy, redir, rpc);
        end
        check("rand_progress", cons_pc.size() >= 100, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ifu_fetch
`default_nettype wire
